// File: rtl/quad_encoder_pkg.sv
// Shared constants and helpers for the quadrature position decoder.
// The forward Gray walk is 00 -> 10 -> 11 -> 01 -> 00, with the bits ordered {A,B}.
package quad_encoder_pkg;

  localparam logic [1:0] QE_MODE_X4 = 2'd0;
  localparam logic [1:0] QE_MODE_X2 = 2'd1;
  localparam logic [1:0] QE_MODE_X1 = 2'd2;

  localparam logic [1:0] QE_S0 = 2'b00;
  localparam logic [1:0] QE_S1 = 2'b10;
  localparam logic [1:0] QE_S2 = 2'b11;
  localparam logic [1:0] QE_S3 = 2'b01;

  typedef struct packed {
    logic counted;
    logic fwd;
    logic illegal;
  } qe_dec_t;

  function automatic logic [1:0] qe_fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      QE_S0:   n = QE_S1;
      QE_S1:   n = QE_S2;
      QE_S2:   n = QE_S3;
      default: n = QE_S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-channel front end: a two-flop synchronizer, then a tick-sampled shift register.
// The filtered level only moves once every sample in the window agrees.
module quad_input_filter #(
  parameter int FILTER_DEPTH = 4
) (
  input  logic clock,
  input  logic srst,
  input  logic tick,
  input  logic raw,
  output logic filt
);

  logic [1:0]              sync_q, sync_d;
  logic [FILTER_DEPTH-1:0] shreg_q, shreg_d;
  logic                    filt_q, filt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    shreg_d = tick ? {shreg_q[FILTER_DEPTH-2:0], sync_q[1]} : shreg_q;
    filt_d  = filt_q;
    if (&shreg_q)       filt_d = 1'b1;
    else if (~|shreg_q) filt_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      sync_q  <= '0;
      shreg_q <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      shreg_q <= shreg_d;
      filt_q  <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/quad_position_decoder.sv
// Quadrature decoder with x1/x2/x4 counting, a wrapping signed position, index clear,
// illegal-transition flag and edge-period measurement for speed estimation.
module quad_position_decoder
  import quad_encoder_pkg::*;
#(
  parameter int SAMPLING_WIDTH = 16,
  parameter int FILTER_DEPTH   = 4,
  parameter int POS_WIDTH      = 32,
  parameter int PERIOD_WIDTH   = 24
) (
  input  logic                      clock,
  input  logic                      srst,
  input  logic [SAMPLING_WIDTH-1:0] sampling,
  input  logic [1:0]                mode,
  input  logic                      channel_a,
  input  logic                      channel_b,
  input  logic                      channel_z,
  input  logic                      index_clear_en,
  input  logic                      pos_load,
  input  logic [POS_WIDTH-1:0]      pos_load_value,
  input  logic                      error_clear,
  output logic [POS_WIDTH-1:0]      position,
  output logic                      direction,
  output logic                      step_pulse,
  output logic                      index_pulse,
  output logic                      error,
  output logic [PERIOD_WIDTH-1:0]   period,
  output logic                      period_valid
);

  logic                      tick;
  logic                      filt_a, filt_b, filt_z;
  logic [SAMPLING_WIDTH-1:0] div_q, div_d;
  logic [1:0]                prev_ab_q, prev_ab_d;
  logic                      prev_z_q, prev_z_d;
  logic [POS_WIDTH-1:0]      pos_q, pos_d;
  logic                      dir_q, dir_d;
  logic                      step_q, step_d;
  logic                      index_q, index_d;
  logic                      err_q, err_d;
  logic [PERIOD_WIDTH-1:0]   per_cnt_q, per_cnt_d;
  logic [PERIOD_WIDTH-1:0]   period_q, period_d;
  logic                      pv_q, pv_d;
  logic [1:0]                cur_ab, ab_chg;
  logic                      z_rise;
  qe_dec_t                   dec;

  quad_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_a (
    .clock(clock), .srst(srst), .tick(tick), .raw(channel_a), .filt(filt_a));
  quad_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_b (
    .clock(clock), .srst(srst), .tick(tick), .raw(channel_b), .filt(filt_b));
  quad_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_z (
    .clock(clock), .srst(srst), .tick(tick), .raw(channel_z), .filt(filt_z));

  // >= rather than == so a sampling value lowered mid-count cannot strand the divider.
  always_comb begin
    tick  = (div_q >= sampling);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    cur_ab      = {filt_a, filt_b};
    ab_chg      = cur_ab ^ prev_ab_q;
    dec.illegal = &ab_chg;
    dec.fwd     = (cur_ab == qe_fwd_next(prev_ab_q));
    dec.counted = 1'b0;
    case (mode)
      QE_MODE_X2: dec.counted = (ab_chg == 2'b10);
      QE_MODE_X1: begin
        dec.counted = (ab_chg == 2'b10) & cur_ab[1];
        dec.fwd     = ~cur_ab[0];
      end
      default:    dec.counted = ^ab_chg;
    endcase
    z_rise    = filt_z & ~prev_z_q;
    prev_ab_d = cur_ab;
    prev_z_d  = filt_z;
  end

  always_comb begin
    pos_d = pos_q;
    if (pos_load)                      pos_d = pos_load_value;
    else if (index_clear_en && z_rise) pos_d = '0;
    else if (dec.counted)              pos_d = dec.fwd ? pos_q + 1'b1 : pos_q - 1'b1;
    dir_d     = dec.counted ? dec.fwd : dir_q;
    step_d    = dec.counted;
    index_d   = z_rise;
    err_d     = dec.illegal | (err_q & ~error_clear);
    per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;
    period_d  = period_q;
    pv_d      = dec.counted;
    if (dec.counted) begin
      per_cnt_d = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
      period_d  = per_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      div_q     <= '0;
      prev_ab_q <= '0;
      prev_z_q  <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      index_q   <= 1'b0;
      err_q     <= 1'b0;
      per_cnt_q <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      prev_ab_q <= prev_ab_d;
      prev_z_q  <= prev_z_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      index_q   <= index_d;
      err_q     <= err_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
    end
  end

  assign position     = pos_q;
  assign direction    = dir_q;
  assign step_pulse   = step_q;
  assign index_pulse  = index_q;
  assign error        = err_q;
  assign period       = period_q;
  assign period_valid = pv_q;

endmodule

// File: tb/tb_quad_position_decoder.sv
// Self-checking bench for quad_position_decoder: vector table, directed corner cases,
// then random encoder walks against a transition-level reference model.
module tb_quad_position_decoder;

  localparam int PW = 12;

  logic          clock = 1'b0;
  logic          srst = 1'b1;
  logic [15:0]   sampling = '0;
  logic [1:0]    mode = '0;
  logic          a = 1'b0, b = 1'b0, z = 1'b0;
  logic          index_clear_en = 1'b0, pos_load = 1'b0, error_clear = 1'b0;
  logic [31:0]   pos_load_value = '0;
  logic [31:0]   position;
  logic          direction, step_pulse, index_pulse, error, period_valid;
  logic [PW-1:0] period;

  int checks = 0;
  int failures = 0;
  int step_cnt = 0, idx_cnt = 0, pv_cnt = 0;
  logic [PW-1:0] last_period = '0;

  quad_position_decoder #(
    .SAMPLING_WIDTH(16), .FILTER_DEPTH(4), .POS_WIDTH(32), .PERIOD_WIDTH(PW)
  ) dut (
    .clock(clock), .srst(srst), .sampling(sampling), .mode(mode),
    .channel_a(a), .channel_b(b), .channel_z(z),
    .index_clear_en(index_clear_en), .pos_load(pos_load), .pos_load_value(pos_load_value),
    .error_clear(error_clear), .position(position), .direction(direction),
    .step_pulse(step_pulse), .index_pulse(index_pulse), .error(error),
    .period(period), .period_valid(period_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (step_pulse)   step_cnt <= step_cnt + 1;
    if (index_pulse)  idx_cnt  <= idx_cnt + 1;
    if (period_valid) begin
      pv_cnt      <= pv_cnt + 1;
      last_period <= period;
    end
  end

  typedef struct {
    logic [1:0] md;
    logic [1:0] ab;
    logic [31:0] pos;
    logic dir;
    logic err;
  } vec_t;

  vec_t vecs[15];
  logic [1:0] fseq[4];
  logic [1:0] rseq[4];
  int gidx[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset;
    a = 0; b = 0; z = 0; mode = 0; sampling = 0;
    pos_load = 0; error_clear = 0; index_clear_en = 0;
    srst = 1; wait_n(2); srst = 0; wait_n(1);
  endtask

  task automatic load_pos(input logic [31:0] v);
    pos_load_value = v; pos_load = 1; wait_n(1); pos_load = 0; wait_n(1);
  endtask

  task automatic run_cycles(input int n, input bit fwd, input int hold);
    for (int c = 0; c < n; c++)
      for (int s = 0; s < 4; s++) begin
        {a, b} = fwd ? fseq[s] : rseq[s];
        wait_n(hold);
      end
  endtask

  initial begin
    int base, lat;
    logic [1:0] cur, nxt, md, diff;
    logic [31:0] m_pos;
    logic m_dir, m_err, d;
    int m_steps;

    fseq = '{2'b10, 2'b11, 2'b01, 2'b00};
    rseq = '{2'b01, 2'b11, 2'b10, 2'b00};
    // walk index of each {A,B} value along the forward sequence
    gidx = '{0, 3, 1, 2};
    vecs[0]  = '{2'd0, 2'b10, 32'd1, 1'b1, 1'b0};
    vecs[1]  = '{2'd0, 2'b11, 32'd2, 1'b1, 1'b0};
    vecs[2]  = '{2'd0, 2'b01, 32'd3, 1'b1, 1'b0};
    vecs[3]  = '{2'd0, 2'b00, 32'd4, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 2'b01, 32'd3, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 2'b11, 32'd2, 1'b0, 1'b0};
    vecs[6]  = '{2'd1, 2'b10, 32'd2, 1'b0, 1'b0};
    vecs[7]  = '{2'd1, 2'b00, 32'd1, 1'b0, 1'b0};
    vecs[8]  = '{2'd2, 2'b10, 32'd2, 1'b1, 1'b0};
    vecs[9]  = '{2'd2, 2'b11, 32'd2, 1'b1, 1'b0};
    vecs[10] = '{2'd2, 2'b01, 32'd2, 1'b1, 1'b0};
    vecs[11] = '{2'd2, 2'b00, 32'd2, 1'b1, 1'b0};
    vecs[12] = '{2'd3, 2'b10, 32'd3, 1'b1, 1'b0};
    vecs[13] = '{2'd3, 2'b01, 32'd3, 1'b1, 1'b1};
    vecs[14] = '{2'd0, 2'b00, 32'd4, 1'b1, 1'b1};

    do_reset;
    chk("reset_position", position, 0);
    chk("reset_direction", direction, 0);
    chk("reset_step_pulse", step_pulse, 0);
    chk("reset_index_pulse", index_pulse, 0);
    chk("reset_error", error, 0);
    chk("reset_period", period, 0);
    chk("reset_period_valid", period_valid, 0);

    // latency: one stable A edge to step_pulse
    lat = 0;
    a = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (step_pulse && lat == 0) lat = i;
    end
    chk("latency_clocks", lat, 8);
    a = 0; wait_n(12);

    // vector table
    do_reset;
    foreach (vecs[i]) begin
      mode = vecs[i].md; {a, b} = vecs[i].ab;
      wait_n(12);
      chk($sformatf("vec%0d_position", i), position, vecs[i].pos);
      chk($sformatf("vec%0d_direction", i), direction, vecs[i].dir);
      chk($sformatf("vec%0d_error", i), error, vecs[i].err);
    end

    // x4 forward/reverse cycles
    do_reset;
    base = step_cnt;
    run_cycles(4, 1, 10); wait_n(12);
    chk("x4_fwd_position", position, 16);
    chk("x4_fwd_direction", direction, 1);
    chk("x4_fwd_steps", step_cnt - base, 16);
    run_cycles(2, 0, 10); wait_n(12);
    chk("x4_rev_position", position, 8);
    chk("x4_rev_direction", direction, 0);

    // x1 then x2
    do_reset;
    mode = 2; run_cycles(3, 1, 10); wait_n(12);
    chk("x1_position", position, 3);
    mode = 1; run_cycles(3, 1, 10); wait_n(12);
    chk("x2_position", position, 9);

    // sampling divider slows the filter but still counts
    do_reset;
    sampling = 3; base = step_cnt;
    run_cycles(1, 1, 40); wait_n(40);
    chk("div_position", position, 4);
    chk("div_steps", step_cnt - base, 4);
    sampling = 0;

    // glitch rejection
    do_reset;
    base = step_cnt;
    a = 1; wait_n(3); a = 0; wait_n(15);
    chk("glitch3_steps", step_cnt - base, 0);
    chk("glitch3_position", position, 0);
    mode = 2;
    a = 1; wait_n(4); a = 0; wait_n(15);
    chk("glitch4_steps", step_cnt - base, 1);
    chk("glitch4_position", position, 1);

    // illegal transitions and sticky error
    do_reset;
    {a, b} = 2'b11; wait_n(12);
    chk("illegal_error", error, 1);
    chk("illegal_position", position, 0);
    error_clear = 1; wait_n(1); error_clear = 0; wait_n(1);
    chk("error_cleared", error, 0);
    {a, b} = 2'b00; wait_n(7);
    error_clear = 1; wait_n(1); error_clear = 0; wait_n(3);
    chk("set_beats_clear", error, 1);
    chk("illegal2_position", position, 0);

    // index clear, load priority, index without clear
    do_reset;
    load_pos(37);
    chk("load37", position, 37);
    base = idx_cnt;
    index_clear_en = 1; z = 1; wait_n(12);
    chk("index_clear_position", position, 0);
    chk("index_pulse_1", idx_cnt - base, 1);
    z = 0; wait_n(12);
    z = 1; wait_n(7);
    pos_load_value = 100; pos_load = 1; wait_n(1); pos_load = 0; wait_n(4);
    chk("load_beats_index", position, 100);
    chk("index_pulse_2", idx_cnt - base, 2);
    z = 0; wait_n(12);
    index_clear_en = 0; z = 1; wait_n(12);
    chk("index_no_clear_position", position, 100);
    chk("index_pulse_3", idx_cnt - base, 3);
    z = 0; wait_n(12);

    // wrap both ways
    do_reset;
    load_pos(32'h7FFF_FFFF);
    a = 1; wait_n(12);
    chk("wrap_max_to_min", position, 32'h8000_0000);
    a = 0; wait_n(12);
    chk("wrap_min_to_max", position, 32'h7FFF_FFFF);

    // period measurement and saturation
    do_reset;
    base = pv_cnt;
    a = 1; wait_n(50); b = 1; wait_n(50); a = 0; wait_n(12);
    chk("period_50", last_period, 50);
    chk("period_valid_count", pv_cnt - base, 3);
    wait_n(5000);
    b = 0; wait_n(12);
    chk("period_saturated", last_period, {PW{1'b1}});

    // synchronous reset mid-run
    srst = 1; wait_n(1);
    chk("midrst_position", position, 0);
    chk("midrst_direction", direction, 0);
    chk("midrst_period", period, 0);
    srst = 0; wait_n(2);

    // random walks against the reference model
    do_reset;
    cur = 2'b00; m_pos = 0; m_dir = 0; m_err = 0; m_steps = 0;
    base = step_cnt;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        error_clear = 1; wait_n(1); error_clear = 0;
        m_err = 0;
      end
      nxt = 2'($urandom_range(0, 3));
      md  = 2'($urandom_range(0, 3));
      mode = md; {a, b} = nxt;
      diff = nxt ^ cur;
      if (diff == 2'b11) m_err = 1;
      else if (diff != 2'b00) begin
        d = (((gidx[nxt] - gidx[cur] + 4) % 4) == 1);
        if (md == 2'd2) d = !nxt[0];
        if (md == 2'd1 ? diff[1] : md == 2'd2 ? (diff[1] && nxt[1]) : 1'b1) begin
          m_pos = d ? m_pos + 1 : m_pos - 1;
          m_dir = d;
          m_steps++;
        end
      end
      cur = nxt;
      wait_n(12);
      chk($sformatf("rnd%0d_position", k), position, m_pos);
      chk($sformatf("rnd%0d_direction", k), direction, m_dir);
      chk($sformatf("rnd%0d_error", k), error, m_err);
    end
    chk("rnd_steps", step_cnt - base, m_steps);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_position_decoder.md
Name: quad_position_decoder

Overview:
- Parametrised quadrature decoder with absolute position counting, for motor-control feedback loops.
- Adds to the basic direction/pulse encoder front end:
  - unanimity glitch filter of configurable depth
  - x1/x2/x4 counting modes
  - signed wrapping position register with load
  - index (Z) channel clear
  - illegal-transition detection
  - edge-period measurement for speed estimation
- Sits between encoder pins (asynchronous) and the motor-control register bank.

Parameters:
- SAMPLING_WIDTH, 16: width of the sampling divider input.
- FILTER_DEPTH, 4: consecutive agreeing samples required to change a filtered level; minimum 2.
- POS_WIDTH, 32: position counter width, two's complement.
- PERIOD_WIDTH, 24: edge-period counter width.

Ports:
- clock  in  1  system clock
- srst  in  1  synchronous reset, active-high
- sampling  in  SAMPLING_WIDTH  sample tick every sampling+1 clocks
- mode  in  2  0=x4, 1=x2, 2=x1, 3=x4
- channel_a  in  1  encoder A, asynchronous
- channel_b  in  1  encoder B, asynchronous
- channel_z  in  1  encoder index, asynchronous
- index_clear_en  in  1  enables position clear on index rising edge
- pos_load  in  1  load strobe
- pos_load_value  in  POS_WIDTH  value loaded on pos_load
- error_clear  in  1  clears sticky error
- position  out  POS_WIDTH  signed position
- direction  out  1  direction of last counted step (1=forward)
- step_pulse  out  1  one-clock pulse per counted step
- index_pulse  out  1  one-clock pulse per filtered Z rising edge
- error  out  1  sticky illegal-transition flag
- period  out  PERIOD_WIDTH  clocks between last two counted steps
- period_valid  out  1  one-clock pulse when period updates

Behaviour:
- Reset: every register cleared, all outputs 0. Filtered A/B/Z levels and previous-state register also 0.
- Synchronizer: each input passes through 2 flops before sampling.
- Sampling divider:
  - Counter runs 0..sampling. Tick asserts when counter == sampling, then the counter returns to 0.
  - sampling=0 gives a tick every clock.
- Filter (per channel):
  - On a tick, the synchronized level shifts into a FILTER_DEPTH shift register.
  - On the clock after, the filtered level takes the shift-register value if all FILTER_DEPTH bits agree; otherwise it holds.
  - Pulses shorter than FILTER_DEPTH ticks never reach the decoder.
- Decode registers the previous filtered {A,B}.
  - Forward sequence: 00->10->11->01->00. Reverse is the opposite order.
  - Counted-step rule per mode:
    - x4: every legal transition.
    - x2: legal transitions where A changes.
    - x1: A rising only. Forward if B=0, reverse if B=1.
  - Illegal transition (both bits change in one update):
    - sets error, no count.
    - previous state still updates to the new value.
- Outputs from a counted step:
  - Position ±1, wrapping modulo 2^POS_WIDTH (max+1 -> min, min-1 -> max).
  - direction updates, step_pulse asserts.
  - All three are registered on the same clock, one clock after the filtered-level change.
- Position priority in one cycle: pos_load > (index_clear_en and Z rising edge) -> 0 > step. A step coinciding with load or index clear is discarded for position, but direction, step_pulse and period still update.
- index_pulse asserts on a filtered Z rising edge regardless of index_clear_en.
- error:
  - Set on an illegal transition; cleared by error_clear.
  - If set and clear happen in the same cycle, set wins.
- period:
  - A free-running counter increments every clock and saturates at all-ones.
  - On each counted step: period <= counter value, period_valid pulses, counter restarts at 1.
  - A saturated value signals standstill.
  - The first step after reset reports the elapsed count (not meaningful).
- End-to-end latency from a stable input to step_pulse: 2 sync clocks + (FILTER_DEPTH-1) ticks after the first sample + 1 filter clock + 1 decode clock.
- srst asserted mid-operation: all state returns to reset values next clock; no pulses emitted.
- mode change mid-run takes effect on the next transition; no retroactive count.

Decomposition:
- Package quad_encoder_pkg:
  - mode constants QE_MODE_X4=2'd0, QE_MODE_X2=2'd1, QE_MODE_X1=2'd2
  - forward-sequence state constants
- Sub-module quad_input_filter:
  - contains the 2-flop sync, FILTER_DEPTH shift register and unanimity hold.
  - Inputs: clock, srst, tick, raw. Output: filt.
  - Instantiated three times (A, B, Z).
- Sampling divider, decode, position and period logic stay in the top module.

Test Plan:
- x4, sampling=0, FILTER_DEPTH=4: 4 full forward cycles, each level held 10 clocks -> position=16, direction=1, 16 step_pulses; then 2 reverse cycles -> position=8, direction=0.
- x1 mode, 3 forward cycles -> position=3. Switch to x2, 3 forward cycles -> position=9.
- Glitch: 3-tick A pulse with FILTER_DEPTH=4 -> no step, position unchanged. 4-tick pulse -> filtered change; only one step counted if B is still.
- Illegal jump 00->11 -> error=1, position unchanged. error_clear -> error=0. Simultaneous illegal jump + error_clear -> error=1.
- Index clear: position=37, index_clear_en=1, Z rising -> position=0, index_pulse=1. Same cycle as pos_load value 100 -> position=100. With index_clear_en=0 -> position kept, index_pulse still 1.
- Wrap and period:
  - pos_load 0x7FFFFFFF then one forward step -> 0x80000000.
  - Steps spaced 50 clocks -> period=50 with period_valid.
  - No steps for 2^24 clocks, then one step -> period=0xFFFFFF.
